// File: rtl/mem_responder.sv
// Memory-side responder: owns the word array and serves data-cache bursts/single reads
// and instruction-cache single reads, data side first.
module mem_responder #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  d_mem_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       d_mem_vis_addr,
  input  logic [LEN-1:0]              d_mem_writen_data,
  input  logic [ENTRY_INDEX_SIZE-1:0] d_write_length,
  output logic [LEN-1:0]              d_mem_data,
  input  logic [1:0]                  i_mem_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       i_mem_vis_addr,
  output logic [LEN-1:0]              i_mem_data,
  output logic                        i_ready,
  output logic [1:0]                  mem_status
);

  // state     | meaning
  // S_IDLE    | resting; serves single reads, starts bursts, accepts inst reads
  // S_D_READ  | data read burst, beats 1..VECTOR_SIZE-1
  // S_D_WRITE | data write burst, beats 1..VECTOR_SIZE-1
  // S_INST    | instruction word registered, i_ready pulse

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;

  localparam logic [1:0] MEM_NOP        = 2'd0;
  localparam logic [1:0] MEM_READ       = 2'd1;
  localparam logic [1:0] MEM_WRITE      = 2'd2;
  localparam logic [1:0] MEM_READ_BURST = 2'd3;

  localparam logic [1:0] MEM_RESTING      = 2'd0;
  localparam logic [1:0] MEM_DATA_WORKING = 2'd1;
  localparam logic [1:0] MEM_INST_WORKING = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_D_READ, S_D_WRITE, S_INST} state_t;

  state_t                      state, state_nx;
  logic [IW-1:0]               base, base_nx;
  logic [ENTRY_INDEX_SIZE-1:0] beat, beat_nx;
  logic [ENTRY_INDEX_SIZE-1:0] len, len_nx;
  logic [LEN-1:0]              i_data_nx;
  logic [IW-1:0]               d_idx, i_idx, idx;
  logic [ENTRY_INDEX_SIZE:0]   len_eff;
  logic                        last_beat;
  logic                        we;
  logic [LEN-1:0]              mem [DEPTH];

  assign d_idx     = d_mem_vis_addr[ADDR_WIDTH-1:2];
  assign i_idx     = i_mem_vis_addr[ADDR_WIDTH-1:2];
  // Read and write share one index; it wraps naturally at the array depth.
  assign idx       = (state == S_IDLE) ? d_idx : base + IW'(beat);
  assign d_mem_data = mem[idx];
  assign len_eff   = (len == '0) ? (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE) : {1'b0, len};
  assign last_beat = (beat == ENTRY_INDEX_SIZE'(VECTOR_SIZE - 1));

  always_comb begin
    state_nx  = state;
    base_nx   = base;
    beat_nx   = beat;
    len_nx    = len;
    i_data_nx = i_mem_data;
    we        = 1'b0;
    case (state)
      S_IDLE: begin
        if (d_mem_vis_signal == MEM_READ_BURST) begin
          base_nx  = d_idx;
          beat_nx  = ENTRY_INDEX_SIZE'(1);
          state_nx = S_D_READ;
        end else if (d_mem_vis_signal == MEM_READ) begin
          state_nx = S_IDLE;
        end else if (d_mem_vis_signal == MEM_WRITE) begin
          we       = 1'b1;
          base_nx  = d_idx;
          len_nx   = d_write_length;
          beat_nx  = ENTRY_INDEX_SIZE'(1);
          state_nx = S_D_WRITE;
        end else if (i_mem_vis_signal == MEM_READ) begin
          i_data_nx = mem[i_idx];
          state_nx  = S_INST;
        end
      end
      S_D_READ: begin
        if (d_mem_vis_signal == MEM_READ_BURST && !last_beat) begin
          beat_nx = beat + 1'b1;
        end else begin
          beat_nx  = '0;
          state_nx = S_IDLE;
        end
      end
      S_D_WRITE: begin
        if (d_mem_vis_signal == MEM_WRITE) begin
          // Beats past the committed length are still counted, just not stored.
          we = ({1'b0, beat} < len_eff);
          if (last_beat) begin
            beat_nx  = '0;
            state_nx = S_IDLE;
          end else begin
            beat_nx = beat + 1'b1;
          end
        end else begin
          beat_nx  = '0;
          state_nx = S_IDLE;
        end
      end
      S_INST:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_status = MEM_RESTING;
    case (state)
      S_D_READ, S_D_WRITE: mem_status = MEM_DATA_WORKING;
      S_INST:              mem_status = MEM_INST_WORKING;
      default:             mem_status = MEM_RESTING;
    endcase
  end

  assign i_ready = (state == S_INST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      base       <= '0;
      beat       <= '0;
      len        <= '0;
      i_mem_data <= '0;
    end else begin
      state      <= state_nx;
      base       <= base_nx;
      beat       <= beat_nx;
      len        <= len_nx;
      i_mem_data <= i_data_nx;
    end
  end

  // Storage is never cleared; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[idx] <= d_mem_writen_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: reference word model plus an expected-read queue.
module tb_mem_responder;

  localparam int AW    = 17;
  localparam int LW    = 32;
  localparam int VS    = 8;
  localparam int EIS   = 3;
  localparam int DEPTH = 1 << (AW - 2);

  localparam logic [1:0] MEM_NOP        = 2'd0;
  localparam logic [1:0] MEM_READ       = 2'd1;
  localparam logic [1:0] MEM_WRITE      = 2'd2;
  localparam logic [1:0] MEM_READ_BURST = 2'd3;

  localparam logic [1:0] MEM_RESTING      = 2'd0;
  localparam logic [1:0] MEM_DATA_WORKING = 2'd1;
  localparam logic [1:0] MEM_INST_WORKING = 2'd2;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     d_sig, i_sig;
  logic [AW-1:0]  d_addr, i_addr;
  logic [LW-1:0]  d_wdata;
  logic [EIS-1:0] d_wlen;
  logic [LW-1:0]  d_mem_data, i_mem_data;
  logic           i_ready;
  logic [1:0]     mem_status;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [int];
  logic [31:0] sb_q [$];
  logic [31:0] iq [$];

  mem_responder #(.ADDR_WIDTH(AW), .LEN(LW), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS)) dut (
    .clk              (clk),
    .rst              (rst),
    .d_mem_vis_signal (d_sig),
    .d_mem_vis_addr   (d_addr),
    .d_mem_writen_data(d_wdata),
    .d_write_length   (d_wlen),
    .d_mem_data       (d_mem_data),
    .i_mem_vis_signal (i_sig),
    .i_mem_vis_addr   (i_addr),
    .i_mem_data       (i_mem_data),
    .i_ready          (i_ready),
    .mem_status       (mem_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input int i);
    return i & (DEPTH - 1);
  endfunction

  task automatic write_burst(input logic [AW-1:0] addr, input logic [EIS-1:0] wlen,
                             input logic [31:0] dbase, input int nbeats);
    int b;
    int eff;
    b   = int'(addr[AW-1:2]);
    eff = (wlen == 0) ? VS : int'(wlen);
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      d_sig = MEM_WRITE; d_addr = addr; d_wdata = dbase + k; d_wlen = wlen;
      if (k < eff) model[widx(b + k)] = dbase + k;
      if (k > 0) begin
        #1 chk("wr_status", {30'd0, mem_status}, {30'd0, MEM_DATA_WORKING});
      end
    end
    @(negedge clk);
    d_sig = MEM_NOP; d_wdata = 32'hDEAD_0000;
    if (nbeats < VS) begin
      #1 chk("abort_status_hold", {30'd0, mem_status}, {30'd0, MEM_DATA_WORKING});
      @(negedge clk);
      d_wdata = 32'hDEAD_0001;
    end
    #1 chk("wr_end_status", {30'd0, mem_status}, {30'd0, MEM_RESTING});
  endtask

  task automatic read_burst(input logic [AW-1:0] addr);
    int b;
    b = int'(addr[AW-1:2]);
    for (int k = 0; k < VS; k++) sb_q.push_back(model[widx(b + k)]);
    for (int k = 0; k < VS; k++) begin
      @(negedge clk);
      d_sig = MEM_READ_BURST; d_addr = addr;
      #1 chk("rd_beat", d_mem_data, sb_q.pop_front());
      if (k > 0) chk("rd_status", {30'd0, mem_status}, {30'd0, MEM_DATA_WORKING});
    end
    @(negedge clk);
    d_sig = MEM_NOP;
    #1 chk("rd_end_status", {30'd0, mem_status}, {30'd0, MEM_RESTING});
  endtask

  task automatic single_read(input int index);
    @(negedge clk);
    d_sig = MEM_READ; d_addr = AW'(index * 4);
    sb_q.push_back(model[widx(index)]);
    #1 chk("rd_single", d_mem_data, sb_q.pop_front());
    chk("rd_single_status", {30'd0, mem_status}, {30'd0, MEM_RESTING});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; d_sig = MEM_NOP; i_sig = MEM_NOP; d_addr = '0; i_addr = '0;
    d_wdata = '0; d_wlen = '0;
    #1;
    chk("rst_status", {30'd0, mem_status}, {30'd0, MEM_RESTING});
    chk("rst_iready", {31'd0, i_ready}, 32'd0);
    chk("rst_idata", i_mem_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // read burst over indices 4..11
    write_burst(17'h10, 3'd0, 32'h100, VS);
    read_burst(17'h10);

    // partial write, then full zero-length write
    write_burst(17'h40, 3'd0, 32'h5500_0000, VS);
    write_burst(17'h40, 3'd3, 32'hA0, VS);
    for (int j = 16; j < 24; j++) single_read(j);
    write_burst(17'h40, 3'd0, 32'hB0, VS);
    read_burst(17'h40);

    // simultaneous data burst and instruction read
    iq.push_back(model[17]);
    for (int k = 0; k < VS; k++) sb_q.push_back(model[4 + k]);
    for (int k = 0; k < VS; k++) begin
      @(negedge clk);
      d_sig = MEM_READ_BURST; d_addr = 17'h10; i_sig = MEM_READ; i_addr = 17'h44;
      #1 chk("prio_beat", d_mem_data, sb_q.pop_front());
      chk("prio_no_iready", {31'd0, i_ready}, 32'd0);
    end
    @(negedge clk);
    d_sig = MEM_NOP;
    #1 chk("prio_rest", {30'd0, mem_status}, {30'd0, MEM_RESTING});
    chk("prio_no_iready_rest", {31'd0, i_ready}, 32'd0);
    cyc = 0;
    do begin
      @(negedge clk);
      #1 cyc++;
    end while (!i_ready && cyc < 4);
    chk("prio_iready", {31'd0, i_ready}, 32'd1);
    chk("prio_idata", i_mem_data, iq.pop_front());
    chk("prio_inst_status", {30'd0, mem_status}, {30'd0, MEM_INST_WORKING});
    i_sig = MEM_NOP;
    @(negedge clk);
    #1 chk("prio_iready_pulse", {31'd0, i_ready}, 32'd0);
    chk("prio_back_rest", {30'd0, mem_status}, {30'd0, MEM_RESTING});

    // wrap from the last word index
    write_burst(17'h1FFFC, 3'd0, 32'hD0, VS);
    read_burst(17'h1FFFC);
    single_read(0);

    // abort after three write beats
    write_burst(17'h80, 3'd0, 32'h11, VS);
    write_burst(17'h80, 3'd0, 32'hC0, 3);
    repeat (3) @(negedge clk);
    read_burst(17'h80);

    // asynchronous reset in the middle of a write burst
    write_burst(17'hC0, 3'd0, 32'h70, VS);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      d_sig = MEM_WRITE; d_addr = 17'hC0; d_wdata = 32'hE0 + k; d_wlen = 3'd0;
      model[48 + k] = 32'hE0 + k;
    end
    @(negedge clk);
    d_wdata = 32'hEE;
    #2 rst = 1'b1;
    #1 chk("midrst_status", {30'd0, mem_status}, {30'd0, MEM_RESTING});
    chk("midrst_iready", {31'd0, i_ready}, 32'd0);
    chk("midrst_idata", i_mem_data, 32'd0);
    @(negedge clk);
    d_sig = MEM_NOP; rst = 1'b0;
    read_burst(17'hC0);
    read_burst(17'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the vector core's cache-to-memory protocol. It owns the word storage array and serves two initiators: the data cache (single-word reads, VECTOR_SIZE-beat read bursts, VECTOR_SIZE-beat write bursts) and the instruction cache (single-word reads). It publishes `mem_status` so each initiator knows when to stall. The data side has strict priority, and the burst address is tracked internally: initiators hold the starting address for the whole burst.

## Interface
- `ADDR_WIDTH`, 17: byte address width. Word index = `addr[ADDR_WIDTH-1:2]`.
- `LEN`, 32: word width.
- `VECTOR_SIZE`, 8: beats per burst.
- `ENTRY_INDEX_SIZE`, 3: width of beat counter and write length.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `d_mem_vis_signal`  in  2  data request (`MEM_NOP` / `MEM_READ` / `MEM_WRITE` / `MEM_READ_BURST`, from src/defines.v).
- `d_mem_vis_addr`  in  ADDR_WIDTH  burst start byte address, held for the whole burst.
- `d_mem_writen_data`  in  LEN  write word for the current beat.
- `d_write_length`  in  ENTRY_INDEX_SIZE  committed write beats; 0 means VECTOR_SIZE.
- `d_mem_data`  out  LEN  read word for the current beat (combinational).
- `i_mem_vis_signal`  in  2  instruction request (`MEM_NOP` / `MEM_READ`).
- `i_mem_vis_addr`  in  ADDR_WIDTH  instruction byte address.
- `i_mem_data`  out  LEN  registered instruction word.
- `i_ready`  out  1  one-cycle pulse: `i_mem_data` is valid.
- `mem_status`  out  2  `MEM_RESTING` / `MEM_DATA_WORKING` / `MEM_INST_WORKING`.

## Operation
- Storage: 2^(ADDR_WIDTH-2) words of LEN bits, with asynchronous read.
  - Reset does not clear storage.
  - Index arithmetic is modulo depth, so a burst wraps from the top index to 0.
- States: IDLE, D_READ, D_WRITE, INST. Registers: `base` (word index), `beat` (ENTRY_INDEX_SIZE bits), `len`.
- `mem_status` is a pure function of state:
  - IDLE → `MEM_RESTING`
  - D_READ / D_WRITE → `MEM_DATA_WORKING`
  - INST → `MEM_INST_WORKING`
- `d_mem_data` = storage[idx]:
  - in IDLE, idx = `d_mem_vis_addr` word index;
  - otherwise, idx = `base + beat`.
- IDLE, on an edge (checked in this order):
  - **`d` = `MEM_READ_BURST`:** beat 0 is consumed this edge. Set `base` ← addr index, `beat` ← 1, go to D_READ.
  - **`d` = `MEM_READ`:** word is consumed this edge; stay IDLE.
  - **`d` = `MEM_WRITE`:** storage[addr index] ← `d_mem_writen_data` (beat 0, always committed). Latch `base` and `len`, set `beat` ← 1, go to D_WRITE.
  - **else, `i` = `MEM_READ`:** `i_mem_data` ← storage[i index], go to INST.
  - **simultaneous d and i requests:** d wins; the i request is not latched and the initiator must hold it.
- D_READ, on an edge:
  - `d` = `MEM_READ_BURST`: beat consumed, `beat`++. If the consumed beat was VECTOR_SIZE-1, go to IDLE and set `beat` ← 0.
  - any other signal: abort to IDLE, `beat` ← 0.
- D_WRITE, on an edge:
  - `d` = `MEM_WRITE`: if `beat < len` (len 0 ≡ VECTOR_SIZE), storage[base+beat] ← `d_mem_writen_data`; otherwise the beat is counted but discarded. `beat`++.
  - After beat VECTOR_SIZE-1, go to IDLE.
  - Any other signal: abort to IDLE. Beats already written remain written.
- INST: `i_ready` = 1 for exactly this cycle, then go to IDLE unconditionally.

## Timing
- Reset values:
  - state IDLE, `mem_status` = `MEM_RESTING`
  - `i_mem_data` = 0, `i_ready` = 0
  - `base` = 0, `beat` = 0, `len` = 0
  - `d_mem_data` follows storage combinationally.
- Reset asserted mid-burst returns to IDLE immediately; no further writes occur.
- Initiator contract: the initiator drives its request in the cycle after it sees `MEM_RESTING`. The edge that samples the request also consumes beat 0.
- Read burst:
  - The request becomes visible after edge N.
  - Beat k is sampled at edge N+1+k, for k = 0..VECTOR_SIZE-1.
  - `mem_status` = `MEM_DATA_WORKING` from after N+1 until after N+VECTOR_SIZE, then `MEM_RESTING`.
- Write burst: same beat timing as a read burst; the write for beat k lands at edge N+1+k.
- Single `MEM_READ`: zero-wait; `mem_status` stays `MEM_RESTING`.
- Instruction read:
  - Accepted at edge N+1.
  - `i_ready` and `i_mem_data` are valid between N+1 and N+2.
  - The next request is accepted no earlier than edge N+2.
- Throughput: one beat per cycle, with no bubbles inside a burst.

## Test plan
- **Read burst:** preload words 0x100..0x107 at indices 4..11, issue `MEM_READ_BURST` at addr 0x10. Expect `d_mem_data` = 0x100..0x107 on 8 consecutive edges, `MEM_DATA_WORKING` for 7 cycles, then `MEM_RESTING`.
- **Partial write:** `MEM_WRITE` at addr 0x40, `d_write_length` = 3, data 0xA0..0xA7. Expect indices 16..18 = 0xA0..0xA2 and indices 19..23 unchanged; a zero-length request writes all 8.
- **Priority:** d `MEM_READ_BURST` and i `MEM_READ` in the same cycle. Expect the d burst first, `i_ready` only after return to `MEM_RESTING`, and the i word correct.
- **Wrap-around:** burst from the last word index. Expect beat 1 read from index 0.
- **Abort:** drop to `MEM_NOP` after 3 write beats. Expect 3 words written, IDLE on the next edge, and no further writes.
- **Reset:** assert `rst` asynchronously mid-burst. Expect `mem_status` = `MEM_RESTING` and `i_ready` = 0 immediately, with storage contents retained.
